gpsdc_lut_ctrl: RTL and testbench

GPSDC_LUT_CTRL -- requirements
Module: gpsdc_lut_ctrl

---
 rtl/gpsdc_lut_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_gpsdc_lut_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gpsdc_lut_ctrl.sv
// ---------------------------------------------------------------------------
// gpsdc_lut_ctrl
//   Two-requester lookup controller for a sorted {key,value} ROM. A request
//   latches its key, scans the ROM from address 0 upward and returns the
//   pair of entries bracketing the key (LO <= key <= HI). Keys outside the
//   table range clamp to the nearest end entry and raise OOR.
//
// Optional feature:
//   GPSDC_LUT_CACHE_EN  - per-requester single-entry result cache; a repeat
//                         of the last key skips the scan (ACK one cycle
//                         after the request is sampled).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   REQ0/REQ1           request levels, held until the matching ACK
//   KEY0/KEY1           query keys, stable while REQ is high
//   ROM_ADDR            registered ROM address
//   ROM_DATA            combinational ROM word {key, value} for ROM_ADDR
//   ACK0/ACK1           one-cycle completion pulses
//   LO_KEY/LO_VAL       lower bracketing entry
//   HI_KEY/HI_VAL       upper bracketing entry
//   OOR                 query key outside [first key, last key]
// ---------------------------------------------------------------------------
module gpsdc_lut_ctrl #(
    parameter int KEY_W  = 48,
    parameter int VAL_W  = 48,
    parameter int ADDR_W = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   REQ0,
    input  logic                   REQ1,
    input  logic [KEY_W-1:0]       KEY0,
    input  logic [KEY_W-1:0]       KEY1,
    output logic [ADDR_W-1:0]      ROM_ADDR,
    input  logic [KEY_W+VAL_W-1:0] ROM_DATA,
    output logic                   ACK0,
    output logic                   ACK1,
    output logic [KEY_W-1:0]       LO_KEY,
    output logic [KEY_W-1:0]       HI_KEY,
    output logic [VAL_W-1:0]       LO_VAL,
    output logic [VAL_W-1:0]       HI_VAL,
    output logic                   OOR
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              id_q, id_d;
    logic              pri_q, pri_d;     // preferred requester on contention
    logic [KEY_W-1:0]  qkey_q, qkey_d;
    logic [KEY_W-1:0]  prev_key_q, prev_key_d;
    logic [VAL_W-1:0]  prev_val_q, prev_val_d;
    logic [KEY_W-1:0]  lo_key_q, lo_key_d, hi_key_q, hi_key_d;
    logic [VAL_W-1:0]  lo_val_q, lo_val_d, hi_val_q, hi_val_d;
    logic              oor_q, oor_d;

    logic [KEY_W-1:0]  rom_key;
    logic [VAL_W-1:0]  rom_val;
    logic              contend;
    logic              grant_id;
    logic [KEY_W-1:0]  sel_key;

    assign rom_key  = ROM_DATA[KEY_W+VAL_W-1:VAL_W];
    assign rom_val  = ROM_DATA[VAL_W-1:0];
    assign contend  = REQ0 & REQ1;
    assign grant_id = contend ? pri_q : REQ1;
    assign sel_key  = grant_id ? KEY1 : KEY0;

`ifdef GPSDC_LUT_CACHE_EN
    logic [1:0]       cvld_q, cvld_d;
    logic [KEY_W-1:0] ckey_q [2];
    logic [KEY_W-1:0] ckey_d [2];
    logic [KEY_W-1:0] clok_q [2];
    logic [KEY_W-1:0] clok_d [2];
    logic [VAL_W-1:0] clov_q [2];
    logic [VAL_W-1:0] clov_d [2];
    logic [KEY_W-1:0] chik_q [2];
    logic [KEY_W-1:0] chik_d [2];
    logic [VAL_W-1:0] chiv_q [2];
    logic [VAL_W-1:0] chiv_d [2];
    logic [1:0]       coor_q, coor_d;
    logic             cache_hit;

    assign cache_hit = cvld_q[grant_id] && (ckey_q[grant_id] == sel_key);
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        pri_d      = pri_q;
        qkey_d     = qkey_q;
        prev_key_d = prev_key_q;
        prev_val_d = prev_val_q;
        lo_key_d   = lo_key_q;
        lo_val_d   = lo_val_q;
        hi_key_d   = hi_key_q;
        hi_val_d   = hi_val_q;
        oor_d      = oor_q;

        case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    id_d   = grant_id;
                    qkey_d = sel_key;
                    // The pointer only moves on a contested grant, so a lone
                    // request does not steal the other side's next turn.
                    if (contend) pri_d = ~grant_id;
`ifdef GPSDC_LUT_CACHE_EN
                    if (cache_hit) begin
                        lo_key_d = clok_q[grant_id];
                        lo_val_d = clov_q[grant_id];
                        hi_key_d = chik_q[grant_id];
                        hi_val_d = chiv_q[grant_id];
                        oor_d    = coor_q[grant_id];
                        state_d  = S_RESP;
                    end else begin
                        addr_d  = '0;
                        state_d = S_SCAN;
                    end
`else
                    addr_d  = '0;
                    state_d = S_SCAN;
`endif
                end
            end

            S_SCAN: begin
                if (rom_key == qkey_q) begin
                    lo_key_d = rom_key;
                    lo_val_d = rom_val;
                    hi_key_d = rom_key;
                    hi_val_d = rom_val;
                    oor_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (rom_key > qkey_q) begin
                    // Below the first entry clamps to entry 0; otherwise the
                    // previous word is the lower bracket.
                    lo_key_d = (addr_q == '0) ? rom_key : prev_key_q;
                    lo_val_d = (addr_q == '0) ? rom_val : prev_val_q;
                    hi_key_d = rom_key;
                    hi_val_d = rom_val;
                    oor_d    = (addr_q == '0);
                    state_d  = S_RESP;
                end else if (addr_q == ADDR_LAST) begin
                    // Above the last entry: clamp, address holds at the end.
                    lo_key_d = rom_key;
                    lo_val_d = rom_val;
                    hi_key_d = rom_key;
                    hi_val_d = rom_val;
                    oor_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    prev_key_d = rom_key;
                    prev_val_d = rom_val;
                    addr_d     = addr_q + ADDR_W'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef GPSDC_LUT_CACHE_EN
    // A freshly resolved scan refreshes the served requester's cache slot.
    always_comb begin
        cvld_d = cvld_q;
        coor_d = coor_q;
        for (int i = 0; i < 2; i++) begin
            ckey_d[i] = ckey_q[i];
            clok_d[i] = clok_q[i];
            clov_d[i] = clov_q[i];
            chik_d[i] = chik_q[i];
            chiv_d[i] = chiv_q[i];
        end
        if (state_q == S_SCAN && state_d == S_RESP) begin
            cvld_d[id_q] = 1'b1;
            coor_d[id_q] = oor_d;
            ckey_d[id_q] = qkey_q;
            clok_d[id_q] = lo_key_d;
            clov_d[id_q] = lo_val_d;
            chik_d[id_q] = hi_key_d;
            chiv_d[id_q] = hi_val_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cvld_q <= '0;
            coor_q <= '0;
            for (int i = 0; i < 2; i++) begin
                ckey_q[i] <= '0;
                clok_q[i] <= '0;
                clov_q[i] <= '0;
                chik_q[i] <= '0;
                chiv_q[i] <= '0;
            end
        end else begin
            cvld_q <= cvld_d;
            coor_q <= coor_d;
            for (int i = 0; i < 2; i++) begin
                ckey_q[i] <= ckey_d[i];
                clok_q[i] <= clok_d[i];
                clov_q[i] <= clov_d[i];
                chik_q[i] <= chik_d[i];
                chiv_q[i] <= chiv_d[i];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            id_q       <= 1'b0;
            pri_q      <= 1'b0;
            qkey_q     <= '0;
            prev_key_q <= '0;
            prev_val_q <= '0;
            lo_key_q   <= '0;
            lo_val_q   <= '0;
            hi_key_q   <= '0;
            hi_val_q   <= '0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            pri_q      <= pri_d;
            qkey_q     <= qkey_d;
            prev_key_q <= prev_key_d;
            prev_val_q <= prev_val_d;
            lo_key_q   <= lo_key_d;
            lo_val_q   <= lo_val_d;
            hi_key_q   <= hi_key_d;
            hi_val_q   <= hi_val_d;
            oor_q      <= oor_d;
        end
    end

    // ACKs decode straight from state, so reset clears them immediately and
    // they are mutually exclusive by construction.
    assign ACK0     = (state_q == S_RESP) && !id_q;
    assign ACK1     = (state_q == S_RESP) &&  id_q;
    assign ROM_ADDR = addr_q;
    assign LO_KEY   = lo_key_q;
    assign LO_VAL   = lo_val_q;
    assign HI_KEY   = hi_key_q;
    assign HI_VAL   = hi_val_q;
    assign OOR      = oor_q;

endmodule

// File: tb/tb_gpsdc_lut_ctrl.sv
module tb_gpsdc_lut_ctrl;

    localparam int KEY_W  = 48;
    localparam int VAL_W  = 48;
    localparam int ADDR_W = 7;

`ifdef GPSDC_LUT_CACHE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 6;
`endif

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   req0 = 1'b0, req1 = 1'b0;
    logic [KEY_W-1:0]       key0 = '0, key1 = '0;
    logic [ADDR_W-1:0]      rom_addr;
    logic [KEY_W+VAL_W-1:0] rom_data;
    logic                   ack0, ack1;
    logic [KEY_W-1:0]       lo_key, hi_key;
    logic [VAL_W-1:0]       lo_val, hi_val;
    logic                   oor;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Table model: key[i] = 10*i, value[i] = i + 1000.
    always_comb begin
        rom_data = {KEY_W'(rom_addr) * KEY_W'(10), VAL_W'(rom_addr) + VAL_W'(1000)};
    end

    gpsdc_lut_ctrl #(.KEY_W(KEY_W), .VAL_W(VAL_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .REQ0(req0), .REQ1(req1), .KEY0(key0), .KEY1(key1),
        .ROM_ADDR(rom_addr), .ROM_DATA(rom_data),
        .ACK0(ack0), .ACK1(ack1),
        .LO_KEY(lo_key), .HI_KEY(hi_key), .LO_VAL(lo_val), .HI_VAL(hi_val),
        .OOR(oor)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_res(input string tag, input int lk, input int lv,
                             input int hk, input int hv, input int o);
        check({tag, "_lo_key"}, 64'(lo_key), 64'(lk));
        check({tag, "_lo_val"}, 64'(lo_val), 64'(lv));
        check({tag, "_hi_key"}, 64'(hi_key), 64'(hk));
        check({tag, "_hi_val"}, 64'(hi_val), 64'(hv));
        check({tag, "_oor"},    64'(oor),    64'(o));
    endtask

    // Called #1 after a rising edge; that cycle is cycle 0 (the sample cycle).
    // Returns at the falling edge of the cycle where the ACK shows up.
    task automatic wait_ack(input int id, input int exp_lat, input string tag);
        int  n     = 0;
        bit  seen  = 0;
        bit  other = 0;
        while (!seen && n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if ((id == 0) ? ack1 : ack0) other = 1;
            if ((id == 0) ? ack0 : ack1) seen = 1;
        end
        check({tag, "_ack_seen"},  64'(seen),  64'd1);
        check({tag, "_latency"},   64'(n),     64'(exp_lat));
        check({tag, "_other_ack"}, 64'(other), 64'd0);
    endtask

    // Drop the served REQ on the edge after the ACK; the ACK must be gone.
    task automatic release_req(input int id, input string tag);
        @(posedge clk);
        #1;
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
        check({tag, "_ack_pulse"}, 64'(ack0 | ack1), 64'd0);
    endtask

    task automatic lookup(input int id, input int key, input int exp_lat, input string tag);
        @(posedge clk);
        #1;
        if (id == 0) begin key0 = KEY_W'(key); req0 = 1'b1; end
        else         begin key1 = KEY_W'(key); req1 = 1'b1; end
        wait_ack(id, exp_lat, tag);
    endtask

    initial begin
        bit any_ack;
        int n;

        // Reset state
        #12;
        check("rst_addr", 64'(rom_addr), 0);
        check("rst_ack",  64'({ack0, ack1}), 0);
        check_res("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Key 35 resolves at index 4 (40 > 35): ACK at k+2 = 6
        lookup(0, 35, 6, "k35");
        check_res("k35", 30, 1003, 40, 1004, 0);
        release_req(0, "k35");

        // Exact hit at index 5
        lookup(1, 50, 7, "k50");
        check_res("k50", 50, 1005, 50, 1005, 0);
        release_req(1, "k50");

        // Above the last key: scan to 127, clamp, no wrap
        lookup(0, 1275, 129, "k1275");
        check_res("k1275", 1270, 1127, 1270, 1127, 1);
        check("k1275_addr", 64'(rom_addr), 127);
        release_req(0, "k1275");

        // Exact hit on entry 0
        lookup(0, 0, 2, "k0");
        check_res("k0", 0, 1000, 0, 1000, 0);
        release_req(0, "k0");

        // Simultaneous pair after reset: REQ0 wins, REQ1 waits
        @(posedge clk);
        #1;
        key0 = 48'd12; key1 = 48'd22; req0 = 1'b1; req1 = 1'b1;
        wait_ack(0, 4, "pairA0");
        check_res("pairA0", 10, 1001, 20, 1002, 0);
        release_req(0, "pairA0");
        wait_ack(1, 5, "pairA1");
        check_res("pairA1", 20, 1002, 30, 1003, 0);
        release_req(1, "pairA1");

        // Next contested pair: REQ1 goes first
        @(posedge clk);
        #1;
        key0 = 48'd15; key1 = 48'd25; req0 = 1'b1; req1 = 1'b1;
        wait_ack(1, 5, "pairB1");
        check_res("pairB1", 20, 1002, 30, 1003, 0);
        release_req(1, "pairB1");
        wait_ack(0, 4, "pairB0");
        check_res("pairB0", 10, 1001, 20, 1002, 0);
        release_req(0, "pairB0");

        // Reset in the middle of a scan at ROM_ADDR 3
        @(posedge clk);
        #1;
        key0 = 48'd35; req0 = 1'b1;
        n = 0;
        any_ack = 0;
        while (rom_addr != 7'd3 && n < 20) begin
            @(negedge clk);
            n++;
            if (ack0 | ack1) any_ack = 1;
        end
        check("mid_addr3_reached", 64'(rom_addr), 3);
        reset_n = 1'b0;
        req0 = 1'b0;
        #1;
        check("mid_rst_addr", 64'(rom_addr), 0);
        check_res("mid_rst", 0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            if (ack0 | ack1) any_ack = 1;
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (ack0 | ack1) any_ack = 1;
        end
        check("mid_no_ack", 64'(any_ack), 0);

        // Reissued request completes normally
        lookup(0, 35, 6, "reissue");
        check_res("reissue", 30, 1003, 40, 1004, 0);
        release_req(0, "reissue");

        // Repeat of the same key: cache hit when enabled, full scan otherwise
        lookup(0, 35, HIT_LAT, "repeat35");
        check_res("repeat35", 30, 1003, 40, 1004, 0);
        release_req(0, "repeat35");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global guard so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
